// File: rtl/weight_loader_pkg.sv
// Shared defaults and FSM encoding for the weight loader.
// Also holds the helper that clamps the requested row count to a legal range.
package weight_loader_pkg;

    localparam int unsigned N_DEFAULT     = 40;
    localparam int unsigned NDATA_DEFAULT = 24;
    localparam int unsigned NADDR_DEFAULT = 9;
    localparam int unsigned DEPTH_DEFAULT = 225;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Zero or an over-range request means "load the whole half-slice".
    function automatic int unsigned effective_rows(input logic [7:0] nrows,
                                                   input int unsigned depth);
        if (nrows == 8'd0 || 32'(nrows) > depth) begin
            return depth;
        end
        return 32'(nrows);
    endfunction

endpackage

// File: rtl/weight_loader.sv
// Collects a stream of weight words into N-lane rows and writes each completed
// row to the weight memory at consecutive row addresses of the selected slice.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned Ndata = NDATA_DEFAULT,
    parameter int unsigned Naddr = NADDR_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           slc,
    input  logic [7:0]           nrows,
    input  logic [Ndata-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [Ndata*N-1:0]   out,
    output logic [Naddr-2:0]     wraddr,
    output logic [1:0]           wrslc,
    output logic                 wren,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = Naddr - 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

    state_e                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [RW-1:0]             row_q, row_d;
    logic [RW-1:0]             last_row_q, last_row_d;
    logic [1:0]                slc_q, slc_d;
    logic [N-1:0][Ndata-1:0]   row_buf_q;
    logic [N-1:0][Ndata-1:0]   row_full;
    logic [N-1:0][Ndata-1:0]   out_q, out_d;
    logic [RW-1:0]             wraddr_q, wraddr_d;
    logic [1:0]                wrslc_q, wrslc_d;

    logic accept;
    logic row_complete;
    logic last_row;

    assign accept       = (state_q == ST_FILL) && din_valid;
    assign row_complete = accept && (lane_q == LAST_LANE);
    assign last_row     = (row_q == last_row_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_FILL;
            ST_FILL:  if (row_complete) state_d = ST_WRITE;
            ST_WRITE: state_d = last_row ? ST_DONE : ST_FILL;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs decoded from the registered state only
    always_comb begin
        din_ready = (state_q == ST_FILL);
        wren      = (state_q == ST_WRITE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_comb begin
        row_full         = row_buf_q;
        row_full[lane_q] = din;
    end

    always_comb begin
        lane_d     = lane_q;
        row_d      = row_q;
        last_row_d = last_row_q;
        slc_d      = slc_q;
        out_d      = out_q;
        wraddr_d   = wraddr_q;
        wrslc_d    = wrslc_q;

        if (state_q == ST_IDLE && start) begin
            slc_d      = slc;
            last_row_d = RW'(effective_rows(nrows, DEPTH) - 1);
            row_d      = '0;
            lane_d     = '0;
        end

        if (accept) begin
            lane_d = row_complete ? '0 : lane_q + 1'b1;
        end

        // The write-side registers are loaded together with the final lane so
        // they present the complete row during the single WRITE cycle.
        if (row_complete) begin
            out_d    = row_full;
            wraddr_d = row_q;
            wrslc_d  = slc_q;
        end

        if (state_q == ST_WRITE) begin
            row_d = row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q     <= '0;
            row_q      <= '0;
            last_row_q <= '0;
            slc_q      <= '0;
            out_q      <= '0;
            wraddr_q   <= '0;
            wrslc_q    <= '0;
        end else begin
            lane_q     <= lane_d;
            row_q      <= row_d;
            last_row_q <= last_row_d;
            slc_q      <= slc_d;
            out_q      <= out_d;
            wraddr_q   <= wraddr_d;
            wrslc_q    <= wrslc_d;
        end
    end

    // NOTE: the lane buffer is deliberately not reset; every lane is rewritten
    // before a row is consumed, so reset would only add fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf_q[lane_q] <= din;
        end
    end

    assign out    = out_q;
    assign wraddr = wraddr_q;
    assign wrslc  = wrslc_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader: a row-level reference model predicts
// every write (address, slice, packed row) and the done pulse that follows.
module tb_weight_loader;

    localparam int NA  = 40;
    localparam int NB  = 4;
    localparam int DW  = 24;
    localparam int AW  = 9;
    localparam int DEP = 225;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default geometry
    logic              start_a = 1'b0;
    logic [1:0]        slc_a = '0;
    logic [7:0]        nrows_a = '0;
    logic [DW-1:0]     din_a = '0;
    logic              din_valid_a = 1'b0;
    logic              din_ready_a;
    logic [DW*NA-1:0]  out_a;
    logic [AW-2:0]     wraddr_a;
    logic [1:0]        wrslc_a;
    logic              wren_a, busy_a, done_a;

    // DUT B: four lanes
    logic              start_b = 1'b0;
    logic [1:0]        slc_b = '0;
    logic [7:0]        nrows_b = '0;
    logic [DW-1:0]     din_b = '0;
    logic              din_valid_b = 1'b0;
    logic              din_ready_b;
    logic [DW*NB-1:0]  out_b;
    logic [AW-2:0]     wraddr_b;
    logic [1:0]        wrslc_b;
    logic              wren_b, busy_b, done_b;

    weight_loader dut_a (
        .clk(clk), .rst(rst), .start(start_a), .slc(slc_a), .nrows(nrows_a),
        .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
        .out(out_a), .wraddr(wraddr_a), .wrslc(wrslc_a), .wren(wren_a),
        .busy(busy_a), .done(done_a)
    );

    weight_loader #(.N(NB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .slc(slc_b), .nrows(nrows_b),
        .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
        .out(out_b), .wraddr(wraddr_b), .wrslc(wrslc_b), .wren(wren_b),
        .busy(busy_b), .done(done_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one entry per row write the loader must perform.
    typedef struct {
        logic [AW-2:0]    addr;
        logic [1:0]       slc;
        logic [DW*NA-1:0] row;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] words_q[$];
    wr_t           mon_e;
    bit            last_wr = 1'b0;
    bit            done_exp;
    int            done_cnt = 0;

    // Write monitor for DUT A, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            done_exp = last_wr;
            last_wr  = 1'b0;
            if (wren_a) begin
                check("ready_low_in_write", din_ready_a, 1'b0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", wren_a, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wraddr", wraddr_a, mon_e.addr);
                    check("wrslc", wrslc_a, mon_e.slc);
                    check("row_data", out_a, mon_e.row);
                    if (exp_q.size() == 0) last_wr = 1'b1;
                end
            end
            check("done_pulse", done_a, done_exp);
            if (done_a) done_cnt++;
        end
    end

    task automatic prep_a(input logic [1:0] s, input logic [7:0] nr, input bit seq);
        int eff;
        logic [DW*NA-1:0] row;
        logic [DW-1:0] w;
        eff = (nr == 0 || int'(nr) > DEP) ? DEP : int'(nr);
        for (int r = 0; r < eff; r++) begin
            row = '0;
            for (int k = 0; k < NA; k++) begin
                w = seq ? DW'(r * NA + k + 1) : DW'($urandom());
                row[k*DW +: DW] = w;
                words_q.push_back(w);
            end
            exp_q.push_back('{addr: AW'(r), slc: s, row: row});
        end
    endtask

    task automatic kick_a(input logic [1:0] s, input logic [7:0] nr);
        @(posedge clk); #1;
        start_a = 1'b1; slc_a = s; nrows_a = nr;
        @(posedge clk); #1;
        start_a = 1'b0; slc_a = 2'($urandom()); nrows_a = 8'($urandom());
        check("busy_after_start", busy_a, 1'b1);
    endtask

    task automatic feed_a(input int max_words, input int pct, input bit poke, input logic [1:0] poke_slc);
        int sent = 0;
        int budget = 0;
        bit poked = 1'b0;
        while (words_q.size() > 0 && sent < max_words && budget < 40000) begin
            din_valid_a = ($urandom_range(99) < pct);
            din_a = words_q[0];
            if (poke && !poked && sent == NA / 2) begin
                start_a = 1'b1; slc_a = poke_slc; poked = 1'b1;
            end
            @(negedge clk);
            if (din_valid_a && din_ready_a) begin
                void'(words_q.pop_front());
                sent++;
            end
            @(posedge clk); #1;
            start_a = 1'b0;
            budget++;
        end
        din_valid_a = 1'b0;
        if (budget >= 40000) check("feed_timeout", budget, 0);
    endtask

    task automatic run_a(input logic [1:0] s, input logic [7:0] nr, input int pct,
                         input bit seq, input bit poke);
        int base;
        int budget = 0;
        base = done_cnt;
        prep_a(s, nr, seq);
        kick_a(s, nr);
        feed_a(1 << 30, pct, poke, ~s);
        check("words_drained", words_q.size(), 0);
        while (done_cnt == base && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        check("done_count", done_cnt - base, 1);
        check("rows_left", exp_q.size(), 0);
        check("idle_after_done", busy_a, 1'b0);
    endtask

    logic [DW*NB-1:0] rows_b[3];
    logic [DW-1:0]    wb_q[$];

    initial begin
        // Reset state
        #12;
        check("rst_out", out_a, '0);
        check("rst_wraddr", wraddr_a, '0);
        check("rst_wrslc", wrslc_a, '0);
        check("rst_wren", wren_a, 1'b0);
        check("rst_ready", din_ready_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        @(posedge clk); #1 rst = 1'b1;

        run_a(2'b01, 8'd2, 100, 1'b1, 1'b0);   // directed 1..80, continuous
        run_a(2'b01, 8'd2, 50, 1'b1, 1'b0);    // same data with stalls
        run_a(2'b10, 8'd1, 70, 1'b0, 1'b1);    // start poked during fill
        run_a(2'b10, 8'd0, 100, 1'b0, 1'b0);   // nrows 0 -> full depth
        run_a(2'b11, 8'd226, 90, 1'b0, 1'b0);  // over-range -> full depth

        // Abort half way through a row
        prep_a(2'b01, 8'd1, 1'b0);
        kick_a(2'b01, 8'd1);
        feed_a(NA / 2, 100, 1'b0, 2'b00);
        #2 rst = 1'b0;
        #1;
        check("abort_out", out_a, '0);
        check("abort_wraddr", wraddr_a, '0);
        check("abort_wrslc", wrslc_a, '0);
        check("abort_wren", wren_a, 1'b0);
        check("abort_ready", din_ready_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        exp_q.delete();
        words_q.delete();
        last_wr = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        run_a(2'b11, 8'd1, 100, 1'b0, 1'b0);

        // Four-lane instance, three rows
        for (int r = 0; r < 3; r++) begin
            rows_b[r] = '0;
            for (int k = 0; k < NB; k++) begin
                logic [DW-1:0] w;
                w = DW'($urandom());
                rows_b[r][k*DW +: DW] = w;
                wb_q.push_back(w);
            end
        end
        @(posedge clk); #1;
        start_b = 1'b1; slc_b = 2'b10; nrows_b = 8'd3;
        @(posedge clk); #1;
        start_b = 1'b0;
        begin
            int acc = 0;
            int wr = 0;
            int dn = 0;
            int budget = 0;
            while (dn == 0 && budget < 500) begin
                din_valid_b = (wb_q.size() > 0) && ($urandom_range(1) == 1);
                din_b = (wb_q.size() > 0) ? wb_q[0] : '0;
                @(negedge clk);
                if (wren_b) begin
                    check("b_words_per_row", acc, NB);
                    acc = 0;
                    if (wr < 3) begin
                        check("b_wraddr", wraddr_b, AW'(wr));
                        check("b_wrslc", wrslc_b, 2'b10);
                        check("b_row", out_b, rows_b[wr]);
                    end else begin
                        check("b_extra_write", wren_b, 1'b0);
                    end
                    wr++;
                end
                if (done_b) dn++;
                if (din_valid_b && din_ready_b) begin
                    void'(wb_q.pop_front());
                    acc++;
                end
                @(posedge clk); #1;
                budget++;
            end
            din_valid_b = 1'b0;
            check("b_write_count", wr, 3);
            check("b_done_seen", dn, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter N, default 40, number of weight lanes (RAM banks) per row.
REQ-002 Parameter Ndata, default 24, bits per weight word.
REQ-003 Parameter Naddr, default 9, weight-memory address width; row address is Naddr-1 bits.
REQ-004 Parameter DEPTH, default 225, rows per half-slice.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle load request; sampled only in IDLE.
REQ-008 slc  input  2  target slice; latched on accepted start.
REQ-009 nrows  input  8  rows to load; latched on accepted start.
REQ-010 din  input  Ndata  streamed weight word.
REQ-011 din_valid  input  1  din valid.
REQ-012 din_ready  output  1  loader accepts din this cycle.
REQ-013 out  output  Ndata*N  packed row to weight memory write data.
REQ-014 wraddr  output  Naddr-1  row address to weight memory.
REQ-015 wrslc  output  2  slice select to weight memory.
REQ-016 wren  output  1  write strobe to weight memory.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  one-cycle pulse after last row written.

Function
REQ-019 FSM states IDLE, FILL, WRITE, DONE; IDLE->FILL on start; FILL->WRITE when lane N-1 accepted; WRITE->FILL if rows remain, else WRITE->DONE; DONE->IDLE unconditionally.
REQ-020 Word accepted iff din_valid && din_ready; din_ready high only in FILL.
REQ-021 Lane counter 0..N-1; accepted word k lands in out[Ndata*(k+1)-1 : Ndata*k]; counter clears on entering WRITE.
REQ-022 Stalls (din_valid low) hold all state; no timeout.
REQ-023 WRITE lasts exactly one cycle: wren=1, wraddr=row counter, wrslc=latched slc, out=packed row; latency = 1 cycle after last lane accepted.
REQ-024 Row counter starts at 0 on start, increments after each WRITE; last row when counter == effective nrows-1.
REQ-025 Effective nrows: nrows if 1..DEPTH; nrows==0 or nrows>DEPTH -> DEPTH.
REQ-026 wren low in all states except WRITE; out, wraddr, wrslc hold last values outside WRITE.
REQ-027 done high exactly in DONE (one cycle); busy low in IDLE only.
REQ-028 start while busy ignored; slc/nrows changes while busy ignored.
REQ-029 All outputs registered or decoded from registered state only; no combinational din->output path except din_ready from state.

Reset
REQ-030 rst low -> immediately IDLE, counters 0, out 0, wraddr 0, wrslc 0, wren 0, din_ready 0, busy 0, done 0.
REQ-031 Reset mid-load abandons partial row; no write issued for it; next start restarts at row 0.

Structure
REQ-032 Shared package holds N, Ndata, Naddr, DEPTH defaults and FSM state encoding constants.
REQ-033 Single module, no sub-module; lane packing as indexed register write, not a shift chain dependent on N>1 ordering.

Verification
REQ-034 start, slc=2'b01, nrows=2, 80 words din=1..80 continuous -> wren at wraddr 0 (lanes 1..40) then wraddr 1 (lanes 41..80), wrslc=01, done one cycle after 2nd write.
REQ-035 nrows=0, slc=2'b10 -> 225 writes wraddr 0..224, wrslc=10, then done; no write at 225.
REQ-036 din_valid toggled 50% random during fill -> identical row contents and addresses as REQ-034; din_ready low in WRITE cycle.
REQ-037 start pulsed during FILL with different slc -> ignored; wrslc keeps original.
REQ-038 rst low after 20 of 40 lanes -> all outputs 0 asynchronously, no wren; new start, 40 words -> write at wraddr 0.
REQ-039 N=4 parameter override, nrows=3 -> 3 writes, each after exactly 4 accepted words.
